// File: rtl/lc3_imem_responder.sv
// lc3_imem_responder
// Instruction memory at the far end of the LC-3 fetch interface. A boot
// stream fills the RAM from word 0. After that the block answers CPU fetch
// requests with one instruction each, one cycle after the request is
// accepted. The response sits in a one-entry output register that holds its
// value while the CPU stalls. Any fetch at or above the loaded length gets
// the HALT word and an error flag.
module lc3_imem_responder #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] HALT_WORD = 16'hF025
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    input  logic              req_valid,
    input  logic [15:0]       req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic [ADDR_W:0]   loaded_len,
    output logic              halt_seen,
    output logic [15:0]       fetch_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Program storage. There is no reset here, so the array maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [LEN_W-1:0]  loaded_len_reg;
    logic              rsp_valid_reg;
    logic              rsp_err_reg;
    logic              rsp_loaded_reg;
    logic              halt_seen_reg;
    logic [15:0]       fetch_count_reg;

    logic ld_fire;
    logic ld_done;
    logic req_fire;
    logic req_hit;
    logic rsp_is_halt;

    // A reload in the same cycle wins, so it suppresses both handshakes.
    assign ld_fire  = ld_valid && ld_ready && !reload;
    assign req_fire = req_valid && req_ready && !reload;

    // Loading ends on the marked last word, or when the RAM is full.
    assign ld_done  = ld_fire && (ld_last || (wr_ptr_reg == ADDR_W'(DEPTH - 1)));

    // The full 16-bit PC is compared against the length. An address whose low
    // bits alias into the RAM must still miss.
    assign req_hit  = req_addr < 16'(loaded_len_reg);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake readies.
    always_comb begin
        state_next = state_reg;
        ld_ready   = 1'b0;
        req_ready  = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_done) begin
                    state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // A new request is taken only if the output slot is free,
                // or is being drained in this cycle.
                req_ready = !rsp_valid_reg || rsp_ready;
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
        if (reload) begin
            state_next = ST_LOAD;
        end
    end

    // RAM write port, fed by the boot stream.
    always_ff @(posedge clk) begin
        if (!rst && ld_fire) begin
            mem[wr_ptr_reg] <= ld_data;
        end
    end

    // RAM registered read port. The read data holds until the next accepted
    // request, which keeps the response stable while the CPU stalls.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            rd_data_reg <= mem[req_addr[ADDR_W-1:0]];
        end
    end

    // Boot write pointer and loaded program length.
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            wr_ptr_reg     <= '0;
            loaded_len_reg <= '0;
        end else if (ld_fire) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            if (ld_done) begin
                loaded_len_reg <= LEN_W'(wr_ptr_reg) + LEN_W'(1);
            end
        end
    end

    // Response slot: valid, the hit/miss flag, and whether any response has
    // ever been loaded since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg  <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_loaded_reg <= 1'b0;
        end else if (reload) begin
            rsp_valid_reg <= 1'b0;
        end else if (req_fire) begin
            rsp_valid_reg  <= 1'b1;
            rsp_err_reg    <= !req_hit;
            rsp_loaded_reg <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    // Output data mux. A miss returns the HALT word instead of the RAM data.
    // Before the first fetch, the output reads zero rather than undefined
    // RAM output.
    always_comb begin
        rsp_instr = '0;
        if (rsp_loaded_reg) begin
            rsp_instr = rsp_err_reg ? HALT_WORD : rd_data_reg;
        end
    end

    assign rsp_is_halt = rsp_valid_reg && (rsp_instr[DATA_W-1 -: 4] == 4'hF);

    // Sticky HALT flag. It shows in the same cycle the HALT response appears,
    // and is captured so that it persists after the response drains.
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            halt_seen_reg <= 1'b0;
        end else if (rsp_is_halt) begin
            halt_seen_reg <= 1'b1;
        end
    end

    // Saturating count of accepted fetch requests.
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            fetch_count_reg <= '0;
        end else if (req_fire && (fetch_count_reg != 16'hFFFF)) begin
            fetch_count_reg <= fetch_count_reg + 16'd1;
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_err     = rsp_err_reg;
    assign loaded_len  = loaded_len_reg;
    assign halt_seen   = halt_seen_reg || rsp_is_halt;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_lc3_imem_responder.sv
// Bench for lc3_imem_responder.
// Directed boot/fetch scenarios, then randomized rounds on an 8-bit-address
// instance. A second instance with 2-bit addresses covers the load that
// ends because the RAM is full.
// Stimulus pushes expected responses into a queue. A negedge monitor pops
// the queue and compares against every response the DUT presents.
module tb_lc3_imem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_last, ld_ready, reload;
    logic [15:0] ld_data;
    logic        req_valid, req_ready, rsp_valid, rsp_err, rsp_ready, halt_seen;
    logic [15:0] req_addr, rsp_instr, fetch_count;
    logic [8:0]  loaded_len;

    logic        s_ld_valid, s_ld_last, s_ld_ready, s_reload;
    logic [15:0] s_ld_data;
    logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_err, s_rsp_ready, s_halt_seen;
    logic [15:0] s_req_addr, s_rsp_instr, s_fetch_count;
    logic [2:0]  s_loaded_len;

    always #5 clk = ~clk;

    lc3_imem_responder #(.ADDR_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .reload(reload),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .loaded_len(loaded_len), .halt_seen(halt_seen), .fetch_count(fetch_count)
    );

    lc3_imem_responder #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(rst),
        .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_ready(s_ld_ready),
        .reload(s_reload),
        .req_valid(s_req_valid), .req_addr(s_req_addr), .req_ready(s_req_ready),
        .rsp_valid(s_rsp_valid), .rsp_instr(s_rsp_instr), .rsp_err(s_rsp_err), .rsp_ready(s_rsp_ready),
        .loaded_len(s_loaded_len), .halt_seen(s_halt_seen), .fetch_count(s_fetch_count)
    );

    typedef struct {
        logic [15:0] instr;
        logic        err;
        logic [15:0] cnt;
        logic        halt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] prog [256];
    int          prog_len;
    logic        in_serve;
    logic [15:0] exp_cnt;
    logic        exp_halt;
    logic [15:0] boot_q[$];
    int          n_checks = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at posedge+1. Streams boot_q into the main DUT and ends at posedge+1.
    task automatic boot_main();
        for (int i = 0; i < boot_q.size(); i++) begin
            ld_valid = 1'b1;
            ld_data  = boot_q[i];
            ld_last  = (i == boot_q.size() - 1);
            #1;
            chk("boot_ld_ready", 32'(ld_ready), 32'd1);
            prog[i] = boot_q[i];
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        prog_len = boot_q.size();
        in_serve = 1'b1;
        $display("boot: %0d words loaded", prog_len);
        chk("boot_loaded_len", 32'(loaded_len), 32'(prog_len));
        chk("boot_ld_ready_off", 32'(ld_ready), 32'd0);
    endtask

    // One cycle of CPU-side stimulus, entered at posedge+1.
    // If the model predicts the request is accepted, its expected response
    // is pushed onto the scoreboard queue.
    task automatic drive(input logic rv, input logic [15:0] a, input logic rr, input logic rl);
        logic exp_ready;
        exp_t e;
        req_valid = rv;
        req_addr  = a;
        rsp_ready = rr;
        reload    = rl;
        #1;
        if (rl) begin
            exp_cnt  = 16'd0;
            exp_halt = 1'b0;
            in_serve = 1'b0;
            prog_len = 0;
            $display("txn: reload");
        end else begin
            exp_ready = in_serve && ((exp_q.size() == 0) || rr);
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            if (rv && exp_ready) begin
                e.err   = !(int'(a) < prog_len);
                e.instr = e.err ? 16'hF025 : prog[a[7:0]];
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                exp_halt = exp_halt | (e.instr[15:12] == 4'hF);
                e.cnt  = exp_cnt;
                e.halt = exp_halt;
                exp_q.push_back(e);
                $display("txn: req addr=%h expect instr=%h err=%0d", a, e.instr, e.err);
            end
        end
        @(posedge clk); #1;
    endtask

    // Monitor: compares every presented response against the queue front.
    // It pops the entry when the response is consumed at the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (reload) begin
            exp_q.delete();
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = exp_q[0];
                chk("rsp_instr", 32'(rsp_instr), 32'(mon_e.instr));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                chk("fetch_count", 32'(fetch_count), 32'(mon_e.cnt));
                chk("halt_seen", 32'(halt_seen), 32'(mon_e.halt));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end else begin
            // With no response showing, the only queued entry may be the
            // request about to be accepted at the next edge.
            chk("rsp_latency", 32'(exp_q.size()), 32'((req_valid && req_ready) ? 1 : 0));
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        ld_valid = 0; ld_last = 0; ld_data = 0; reload = 0;
        req_valid = 0; req_addr = 0; rsp_ready = 0;
        s_ld_valid = 0; s_ld_last = 0; s_ld_data = 0; s_reload = 0;
        s_req_valid = 0; s_req_addr = 0; s_rsp_ready = 0;
        prog_len = 0; in_serve = 0; exp_cnt = 0; exp_halt = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values.
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_instr", 32'(rsp_instr), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_halt_seen", 32'(halt_seen), 32'd0);
        chk("rst_fetch_count", 32'(fetch_count), 32'd0);
        chk("rst_loaded_len", 32'(loaded_len), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // Scenario 1: boot three words.
        boot_q = '{16'h1261, 16'h1262, 16'hF025};
        boot_main();
        chk("s1_loaded_len", 32'(loaded_len), 32'd3);
        chk("s1_req_ready", 32'(req_ready), 32'd1);

        // Scenario 2: fetch addr 1.
        drive(1'b1, 16'd1, 1'b1, 1'b0);
        chk("s2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("s2_rsp_instr", 32'(rsp_instr), 32'h1262);
        chk("s2_fetch_count", 32'(fetch_count), 32'd1);
        drive(1'b0, 16'd0, 1'b1, 1'b0);

        // Scenario 3: stall with addr 0 held, then accept addr 2.
        drive(1'b1, 16'd0, 1'b1, 1'b0);
        drive(1'b1, 16'd2, 1'b0, 1'b0);
        chk("s3_req_ready", 32'(req_ready), 32'd0);
        chk("s3_hold_instr", 32'(rsp_instr), 32'h1261);
        drive(1'b1, 16'd2, 1'b0, 1'b0);
        chk("s3_hold_instr2", 32'(rsp_instr), 32'h1261);
        drive(1'b1, 16'd2, 1'b1, 1'b0);
        chk("s3_instr", 32'(rsp_instr), 32'hF025);
        chk("s3_halt_seen", 32'(halt_seen), 32'd1);
        drive(1'b0, 16'd0, 1'b1, 1'b0);

        // Scenario 4: aliasing out-of-range address.
        drive(1'b1, 16'h0105, 1'b1, 1'b0);
        chk("s4_instr", 32'(rsp_instr), 32'hF025);
        chk("s4_err", 32'(rsp_err), 32'd1);

        // Scenario 6: reload while a response is pending and a request is presented.
        drive(1'b1, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 16'd1, 1'b1, 1'b1);
        chk("s6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("s6_ld_ready", 32'(ld_ready), 32'd1);
        chk("s6_halt_seen", 32'(halt_seen), 32'd0);
        chk("s6_fetch_count", 32'(fetch_count), 32'd0);
        chk("s6_loaded_len", 32'(loaded_len), 32'd0);
        reload = 1'b0; req_valid = 1'b0;

        // Randomized rounds: boot a random program, then issue random fetches.
        for (int r = 0; r < 8; r++) begin
            drive(1'b0, 16'd0, 1'b1, 1'b1);
            reload = 1'b0;
            n = $urandom_range(1, 24);
            boot_q.delete();
            for (int i = 0; i < n; i++) boot_q.push_back(16'($urandom));
            boot_main();
            for (int c = 0; c < 50; c++) begin
                logic [15:0] a;
                logic        rl;
                a  = ($urandom % 5 == 0) ? 16'($urandom) : 16'($urandom_range(0, n + 2));
                rl = ($urandom % 80 == 0);
                drive(($urandom % 4) != 0, a, ($urandom % 3) != 0, rl);
                if (rl) break;
            end
            drive(1'b0, 16'd0, 1'b1, 1'b0);
            drive(1'b0, 16'd0, 1'b1, 1'b0);
            chk("drain_queue", 32'(exp_q.size()), 32'd0);
        end

        // Scenario 5: 4-word RAM fills without ld_last.
        for (int i = 0; i < 4; i++) begin
            s_ld_valid = 1'b1;
            s_ld_data  = 16'h1000 + 16'(i);
            #1;
            chk("s5_ld_ready", 32'(s_ld_ready), 32'd1);
            @(posedge clk); #1;
        end
        s_ld_data = 16'h1ABC;
        #1;
        chk("s5_ld_ready_full", 32'(s_ld_ready), 32'd0);
        chk("s5_loaded_len", 32'(s_loaded_len), 32'd4);
        @(posedge clk); #1;
        s_ld_valid = 1'b0;
        chk("s5_loaded_len_hold", 32'(s_loaded_len), 32'd4);
        s_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_req_valid = 1'b1;
            s_req_addr  = 16'(i);
            #1;
            chk("s5_req_ready", 32'(s_req_ready), 32'd1);
            @(posedge clk); #1;
            s_req_valid = 1'b0;
            $display("txn: small req addr=%0d instr=%h err=%0d", i, s_rsp_instr, s_rsp_err);
            chk("s5_rsp_valid", 32'(s_rsp_valid), 32'd1);
            chk("s5_rsp_instr", 32'(s_rsp_instr), (i < 4) ? 32'h1000 + 32'(i) : 32'hF025);
            chk("s5_rsp_err", 32'(s_rsp_err), (i < 4) ? 32'd0 : 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
